// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word
// reads, buffers in-order responses in a prefetch FIFO and flushes on redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptrType;
  typedef logic [CNT_W-1:0] cntType;

  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);
  localparam ptrType         PTR_ONE = ptrType'(1);

  logic [31:0] fetchPc;
  logic [31:0] fifoPc    [DEPTH];
  logic [31:0] fifoInstr [DEPTH];
  logic [31:0] pcQueue   [DEPTH];

  ptrType rdPtr, wrPtr, pcqRdPtr, pcqWrPtr;
  cntType count, outstanding, discard;
  cntType countNext, outstandingNext, discardNext;

  logic           reqFire, respTake, respKeep, deqFire;
  logic [CNT_W:0] creditsUsed;
  logic [1:0]     unusedPcBits;

  assign unusedPcBits = redirect_pc[1:0];

  // Every buffered entry and every in-flight request holds one credit.
  assign creditsUsed    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (creditsUsed < CREDITS) && !redirect;
  assign imem_req_addr  = fetchPc;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifoInstr[rdPtr] : '0;
  assign instr_pc    = instr_valid ? fifoPc[rdPtr]    : '0;

  assign reqFire  = imem_req_valid && imem_req_ready;
  assign respTake = imem_resp_valid && (outstanding != '0);
  assign respKeep = respTake && (discard == '0) && !redirect;
  assign deqFire  = instr_valid && instr_ready && !redirect;

  // NOTE: next-state values use blocking assignments in always_comb, each with a
  // default first so no latch is inferred; the registers below take them with <=.
  always_comb begin
    outstandingNext = outstanding + cntType'(reqFire) - cntType'(respTake);
    countNext       = count + cntType'(respKeep) - cntType'(deqFire);
    discardNext     = discard;
    if (respTake && (discard != '0)) begin
      discardNext = discard - cntType'(1);
    end
    if (redirect) begin
      countNext   = '0;
      discardNext = outstandingNext;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetchPc     <= RESET_PC;
      rdPtr       <= '0;
      wrPtr       <= '0;
      pcqRdPtr    <= '0;
      pcqWrPtr    <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      count       <= countNext;
      outstanding <= outstandingNext;
      discard     <= discardNext;
      if (redirect) begin
        fetchPc <= {redirect_pc[31:2], 2'b00};
        rdPtr   <= '0;
        wrPtr   <= '0;
      end else begin
        if (reqFire)  fetchPc <= fetchPc + 32'd4;
        if (respKeep) wrPtr   <= wrPtr + PTR_ONE;
        if (deqFire)  rdPtr   <= rdPtr + PTR_ONE;
      end
      // In-flight address tracking survives redirects: stale responses still arrive in order.
      if (reqFire)  pcqWrPtr <= pcqWrPtr + PTR_ONE;
      if (respTake) pcqRdPtr <= pcqRdPtr + PTR_ONE;
    end
  end

  // NOTE: storage arrays carry no reset; an entry is only read after it has been
  // written, as guarded by count and outstanding.
  always_ff @(posedge clock) begin
    if (respKeep) begin
      fifoPc[wrPtr]    <= pcQueue[pcqRdPtr];
      fifoInstr[wrPtr] <= imem_resp_data;
    end
    if (reqFire) begin
      pcQueue[pcqWrPtr] <= fetchPc;
    end
  end

endmodule
